gesture_stroke_scheduler: RTL



---
 rtl/gesture_stroke_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gesture_stroke_scheduler.sv
// Gesture stroke scheduler: windows a position stream into a saturated stroke delta,
// drives one classifier request per stroke and hands the result downstream.
//
// state     | meaning
// S_IDLE    | waiting for the first sample of a stroke (anchor)
// S_COLLECT | counting samples until the window is full
// S_EVAL    | saturate delta, compare magnitude to threshold
// S_ISSUE   | one-cycle classifier request
// S_WAIT    | waiting for classifier result, bounded by TIMEOUT
// S_PRESENT | result held on gest_valid until downstream accepts
// S_COOL    | idle cooldown before the next stroke may open
module gesture_stroke_scheduler #(
  parameter int DATA_BITS = 16,
  parameter int WINDOW    = 8,
  parameter int THRESH    = 32,
  parameter int TIMEOUT   = 16,
  parameter int COOLDOWN  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  input  logic signed [DATA_BITS-1:0] sample_x,
  input  logic signed [DATA_BITS-1:0] sample_y,
  output logic                        cls_delta_valid,
  output logic signed [DATA_BITS-1:0] cls_delta_x,
  output logic signed [DATA_BITS-1:0] cls_delta_y,
  input  logic [1:0]                  cls_gesture,
  input  logic                        cls_gesture_valid,
  output logic                        gest_valid,
  output logic [1:0]                  gest_code,
  input  logic                        gest_ready,
  output logic                        busy,
  output logic                        drop_pulse,
  output logic                        timeout_pulse
);

  localparam int W1      = DATA_BITS + 1;
  localparam int CNT_W   = $clog2(WINDOW + 1);
  localparam int TMR_MAX = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CD_LOAD = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_EVAL, S_ISSUE, S_WAIT, S_PRESENT, S_COOL
  } state_t;

  // With no cooldown configured, finished strokes fall straight back to IDLE.
  localparam state_t S_AFTER = (COOLDOWN == 0) ? S_IDLE : S_COOL;

  state_t                        state;
  logic [CNT_W-1:0]              sample_cnt;
  logic [TMR_W-1:0]              timer;
  logic signed [DATA_BITS-1:0]   anchor_x, anchor_y, last_x, last_y;
  logic signed [W1-1:0]          dx_raw, dy_raw;
  logic signed [DATA_BITS-1:0]   dx_sat, dy_sat;
  logic [W1-1:0]                 mag;

  function automatic logic signed [DATA_BITS-1:0] sat(input logic signed [W1-1:0] v);
    if (v[W1-1] != v[W1-2])
      return v[W1-1] ? {1'b1, {(DATA_BITS-1){1'b0}}} : {1'b0, {(DATA_BITS-1){1'b1}}};
    else
      return v[DATA_BITS-1:0];
  endfunction

  // One extra bit keeps |most-negative| exact.
  function automatic logic [W1-1:0] absval(input logic signed [DATA_BITS-1:0] v);
    logic [W1-1:0] e;
    e = {v[DATA_BITS-1], v};
    return v[DATA_BITS-1] ? (~e + 1'b1) : e;
  endfunction

  always_comb begin
    dx_raw = {last_x[DATA_BITS-1], last_x} - {anchor_x[DATA_BITS-1], anchor_x};
    dy_raw = {last_y[DATA_BITS-1], last_y} - {anchor_y[DATA_BITS-1], anchor_y};
    dx_sat = sat(dx_raw);
    dy_sat = sat(dy_raw);
    mag    = absval(dx_sat) + absval(dy_sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      sample_cnt      <= '0;
      timer           <= '0;
      anchor_x        <= '0;
      anchor_y        <= '0;
      last_x          <= '0;
      last_y          <= '0;
      cls_delta_valid <= 1'b0;
      cls_delta_x     <= '0;
      cls_delta_y     <= '0;
      gest_valid      <= 1'b0;
      gest_code       <= '0;
      busy            <= 1'b0;
      drop_pulse      <= 1'b0;
      timeout_pulse   <= 1'b0;
    end else begin
      cls_delta_valid <= 1'b0;
      drop_pulse      <= 1'b0;
      timeout_pulse   <= 1'b0;
      case (state)
        S_IDLE: if (sample_valid) begin
          anchor_x   <= sample_x;
          anchor_y   <= sample_y;
          sample_cnt <= CNT_W'(1);
          state      <= S_COLLECT;
          busy       <= 1'b1;
        end
        S_COLLECT: if (sample_valid) begin
          sample_cnt <= sample_cnt + 1'b1;
          if (sample_cnt == CNT_W'(WINDOW - 1)) begin
            last_x <= sample_x;
            last_y <= sample_y;
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (mag >= W1'(THRESH)) begin
            cls_delta_x     <= dx_sat;
            cls_delta_y     <= dy_sat;
            cls_delta_valid <= 1'b1;
            state           <= S_ISSUE;
          end else begin
            drop_pulse <= 1'b1;
            state      <= S_AFTER;
            timer      <= TMR_W'(CD_LOAD);
            busy       <= (COOLDOWN != 0);
          end
        end
        S_ISSUE: begin
          timer <= TMR_W'(TIMEOUT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cls_gesture_valid) begin
            gest_code  <= cls_gesture;
            gest_valid <= 1'b1;
            state      <= S_PRESENT;
          end else if (timer == '0) begin
            timeout_pulse <= 1'b1;
            state         <= S_AFTER;
            timer         <= TMR_W'(CD_LOAD);
            busy          <= (COOLDOWN != 0);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_PRESENT: if (gest_ready) begin
          gest_valid <= 1'b0;
          state      <= S_AFTER;
          timer      <= TMR_W'(CD_LOAD);
          busy       <= (COOLDOWN != 0);
        end
        S_COOL: begin
          if (timer == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
